// File: rtl/noc_rr_arbiter_lock.sv
// Round-robin output-port arbiter with wormhole packet locking.
// Grant is registered and one-hot; gnt_idx_o doubles as the lock owner.
module noc_rr_arbiter_lock #(
   parameter int unsigned  NUM_PORTS = 5,
   parameter bit           LOCK_MODE = 1'b1,
   localparam int unsigned IDX_W     = $clog2(NUM_PORTS)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [NUM_PORTS-1:0] req_i,
   input  logic [NUM_PORTS-1:0] tail_i,
   output logic [NUM_PORTS-1:0] gnt_o,
   output logic                 gnt_valid_o,
   output logic [IDX_W-1:0]     gnt_idx_o
);

   typedef enum logic [0:0] {StIdle, StBusy} state_e;

   localparam logic [IDX_W:0]   NumP    = (IDX_W+1)'(NUM_PORTS);
   localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_PORTS - 1);

   state_e                 state_q, state_d;
   logic [NUM_PORTS-1:0]   gnt_q, gnt_d;
   logic                   valid_q, valid_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [IDX_W-1:0]       ptr_q, ptr_d;

   logic                   hold, rel, found;
   logic [IDX_W-1:0]       base, win;
   logic [IDX_W:0]         sum;

   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] x);
      return (x == LastIdx) ? '0 : x + 1'b1;
   endfunction

   // On release the search starts just past the old owner, otherwise at ptr.
   always_comb begin
      hold  = LOCK_MODE && (state_q == StBusy) && req_i[idx_q] && !tail_i[idx_q];
      rel   = LOCK_MODE && (state_q == StBusy) && !hold;
      base  = rel ? next_idx(idx_q) : ptr_q;
      found = 1'b0;
      win   = '0;
      sum   = '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         sum = {1'b0, base} + (IDX_W+1)'(i);
         if (sum >= NumP) sum = sum - NumP;
         if (!found && req_i[sum[IDX_W-1:0]]) begin
            found = 1'b1;
            win   = sum[IDX_W-1:0];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      valid_d = valid_q;
      idx_d   = idx_q;
      ptr_d   = ptr_q;
      if (!hold) begin
         gnt_d   = '0;
         valid_d = found;
         if (found) begin
            gnt_d[win] = 1'b1;
            idx_d      = win;
            state_d    = StBusy;
         end else begin
            state_d    = StIdle;
         end
         if (rel) begin
            ptr_d = base;
         end else if (!LOCK_MODE && found) begin
            ptr_d = next_idx(win);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         gnt_q   <= '0;
         valid_q <= 1'b0;
         idx_q   <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         valid_q <= valid_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
      end
   end

   assign gnt_o       = gnt_q;
   assign gnt_valid_o = valid_q;
   assign gnt_idx_o   = idx_q;

   a_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt_o));
   a_valid  : assert property (@(posedge clk_i) disable iff (!rst_ni) gnt_valid_o == |gnt_o);
   a_index  : assert property (@(posedge clk_i) disable iff (!rst_ni)
                               gnt_valid_o |-> gnt_o[gnt_idx_o]);

endmodule

// File: tb/tb_noc_rr_arbiter_lock.sv
// Scoreboard bench: a locking and a non-locking 5-port arbiter share stimulus;
// a queue-based reference model predicts each grant, a monitor compares.
module tb_noc_rr_arbiter_lock;

   localparam int N = 5;

   typedef struct packed {
      logic [4:0] gnt;
      logic       valid;
      logic [2:0] idx;
   } exp_t;

   logic       clk, rst_n;
   logic [4:0] req, tail;
   logic [4:0] gnt1, gnt0;
   logic       v1, v0;
   logic [2:0] idx1, idx0;

   exp_t q1[$];
   exp_t q0[$];
   int   ptr_m[2];
   int   own_m[2];
   int   last_m[2];
   int   n_tests = 0;
   int   n_fail  = 0;

   noc_rr_arbiter_lock #(.NUM_PORTS(N), .LOCK_MODE(1'b1)) u_lock (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req), .tail_i(tail),
      .gnt_o(gnt1), .gnt_valid_o(v1), .gnt_idx_o(idx1)
   );

   noc_rr_arbiter_lock #(.NUM_PORTS(N), .LOCK_MODE(1'b0)) u_free (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req), .tail_i(tail),
      .gnt_o(gnt0), .gnt_valid_o(v0), .gnt_idx_o(idx0)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input exp_t act, input exp_t exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got gnt=%b valid=%b idx=%0d, expected gnt=%b valid=%b idx=%0d",
                  name, $time, act.gnt, act.valid, act.idx, exp.gnt, exp.valid, exp.idx);
      end
   endtask

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         ptr_m[m]  = 0;
         own_m[m]  = -1;
         last_m[m] = 0;
      end
   endtask

   // Mode 1 keeps the owner while it requests without tail; otherwise the
   // pointer moves past the old owner and a fresh circular search runs.
   task automatic model_step(input int m, input logic [4:0] r, input logic [4:0] t,
                             output exp_t e);
      int  w;
      bit  keep;
      keep = (m == 1) && (own_m[m] >= 0) && r[own_m[m]] && !t[own_m[m]];
      if (!keep) begin
         if (m == 1 && own_m[m] >= 0) ptr_m[m] = (own_m[m] + 1) % N;
         w = -1;
         for (int k = 0; k < N; k++)
            if (w < 0 && r[(ptr_m[m] + k) % N]) w = (ptr_m[m] + k) % N;
         if (m == 0 && w >= 0) ptr_m[m] = (w + 1) % N;
         own_m[m] = w;
         if (w >= 0) last_m[m] = w;
      end
      e.gnt   = (own_m[m] >= 0) ? 5'(1 << own_m[m]) : 5'b0;
      e.valid = (own_m[m] >= 0);
      e.idx   = 3'(last_m[m]);
   endtask

   // Called at posedge+2; applies inputs for the coming edge, returns at posedge+2.
   task automatic drive(input logic [4:0] r, input logic [4:0] t);
      exp_t e;
      req  = r;
      tail = t;
      model_step(1, r, t, e);
      q1.push_back(e);
      model_step(0, r, t, e);
      q0.push_back(e);
      @(posedge clk);
      #2;
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_lock"}, {gnt1, v1, idx1}, '0);
      check({name, "_free"}, {gnt0, v0, idx0}, '0);
   endtask

   // Asserts reset between edges and checks outputs clear before any clock.
   task automatic do_reset(input string name);
      req  = '0;
      tail = '0;
      #3;
      rst_n = 1'b0;
      #1;
      check_reset_outputs(name);
      q1.delete();
      q0.delete();
      model_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q1.size() != 0) begin
            e = q1.pop_front();
            check("grant_lock", {gnt1, v1, idx1}, e);
         end
         if (q0.size() != 0) begin
            e = q0.pop_front();
            check("grant_free", {gnt0, v0, idx0}, e);
         end
      end
   end

   initial begin
      logic [31:0] r, t;
      rst_n = 1'b1;
      req   = '0;
      tail  = '0;
      model_reset();
      #1 rst_n = 1'b0;
      #2;
      check_reset_outputs("por");
      @(posedge clk);
      #2;
      rst_n = 1'b1;

      // Single short packet, then idle
      drive(5'b00010, 5'b00010);
      drive(5'b00000, 5'b00000);
      drive(5'b00000, 5'b00000);

      // All ports with tail every cycle: zero-bubble rotation
      do_reset("rst_t2");
      repeat (6) drive(5'b11111, 5'b11111);
      drive(5'b00000, 5'b00000);

      // Lock held for 4 granted cycles, then handover to port 3
      do_reset("rst_t3");
      repeat (4) drive(5'b01001, 5'b00000);
      drive(5'b01001, 5'b00001);
      drive(5'b01000, 5'b00000);
      drive(5'b00000, 5'b00000);

      // Owner abandons without tail
      do_reset("rst_t4");
      drive(5'b00100, 5'b00000);
      drive(5'b10100, 5'b00000);
      drive(5'b10000, 5'b00000);
      drive(5'b00000, 5'b00000);

      // Pointer wraps past the last port
      do_reset("rst_t5");
      drive(5'b01000, 5'b00000);
      drive(5'b01001, 5'b01000);
      drive(5'b00000, 5'b00000);

      // Reset in the middle of a locked packet
      drive(5'b00100, 5'b00000);
      drive(5'b10100, 5'b00000);
      do_reset("rst_mid");
      drive(5'b10000, 5'b00000);
      drive(5'b00000, 5'b00000);

      // Random traffic with biased-high requests and sparse tails
      repeat (500) begin
         r = $urandom | $urandom;
         t = $urandom & $urandom;
         if ($urandom_range(0, 99) == 0) do_reset("rst_rand");
         drive(r[4:0], t[4:0]);
      end
      drive(5'b00000, 5'b00000);

      repeat (2) @(posedge clk);
      #2;
      n_tests++;
      if (q1.size() + q0.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending expectations, expected 0", q1.size() + q0.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/noc_rr_arbiter_lock.md
Name: noc_rr_arbiter_lock

Overview:
Parametrised round-robin arbiter for the router output ports. It generalises the fixed 5-port arbiter to NUM_PORTS requesters. It adds packet locking: under wormhole switching, a grant is held until the tail flit. Grant is registered and one-hot, and the arbiter sits between the input-port request logic and the crossbar select.

Parameters:
NUM_PORTS, 5, number of requesting input ports (2..16)
LOCK_MODE, 1, 1 = hold grant until tail/request drop; 0 = re-arbitrate every cycle
IDX_W, $clog2(NUM_PORTS), width of gnt_idx (derived, not overridden)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-low reset
req  input  NUM_PORTS  per-port request, level
tail  input  NUM_PORTS  per-port tail-flit marker, sampled only for the current owner
gnt  output  NUM_PORTS  one-hot registered grant
gnt_valid  output  1  OR of gnt, registered
gnt_idx  output  IDX_W  binary index of granted port; holds last value when gnt_valid=0

Behaviour:
- Reset (rst=0, asynchronous): gnt=0, gnt_valid=0, gnt_idx=0, priority pointer ptr=0 (port 0 highest), state=IDLE. Outputs clear immediately without waiting for clk.
- Reset release: the first rising edge with rst=1 evaluates normally.
- Latency: a request sampled at edge k produces gnt at edge k (visible after k, i.e. 1-cycle registered path). There is no combinational req->gnt path.
- Arbitration function: search ports ptr, ptr+1, ... NUM_PORTS-1, 0, ... ptr-1 modulo NUM_PORTS. The first port with req=1 wins.
- FSM, LOCK_MODE=1:
  - IDLE: if |req, grant the winner, set owner, go to BUSY. Otherwise stay, gnt=0.
  - BUSY, hold condition req[owner]=1 and tail[owner]=0: hold gnt unchanged. Other requests are ignored.
  - BUSY, release condition req[owner]=0, or req[owner]=1 and tail[owner]=1: set ptr=(owner+1) mod NUM_PORTS. On the same edge, arbitrate with the new ptr over req, where the owner's req counts only if it is still asserted. If there is a winner, grant it and stay BUSY (zero-bubble handover). Otherwise go to IDLE with gnt=0.
  - Release on the tail cycle: the owner keeps gnt during the cycle where tail is asserted. The tail flit is transferred and gnt changes at the following edge.
- LOCK_MODE=0: arbitrate at every edge. After each edge with a grant, ptr=(winner+1) mod NUM_PORTS. tail is ignored.
- Single requester: with LOCK_MODE=0 it is granted every cycle. With LOCK_MODE=1 it is re-granted immediately after its tail if it is still requesting.
- Pointer rules: ptr only updates on release (mode 1) or on a grant (mode 0), never in IDLE with no requests.
- Wrap-around: owner=NUM_PORTS-1 gives ptr=0.
- tail asserted without req on a non-owner port: ignored.
- Invariants: gnt is always one-hot or zero. gnt_valid equals |gnt. When gnt_valid=1, gnt_idx equals the index of the set gnt bit.
- Reset mid-packet: lock is lost, ptr returns to 0, and re-arbitration starts from IDLE.

Test Plan:
1. N=5, LOCK_MODE=1. Release reset, then drive req=00010 for 1 cycle with tail=00010 -> gnt=00010, gnt_idx=1 the next cycle. The following cycle gnt=0, gnt_valid=0, ptr=2.
2. N=5, LOCK_MODE=1. Hold req=11111 with tail=11111 continuously -> grant sequence is port 0,1,2,3,4,0, each held 1 cycle, with no idle cycles.
3. Lock hold: hold req0 for 4 cycles with tail0 asserted only on the 4th, and hold req3=1 throughout -> gnt=00001 for 4 consecutive cycles. Then gnt=01000 on the next cycle with no bubble.
4. Abandon: the owner (port 2) drops req without tail while req4=1 -> at the next edge gnt=10000 and ptr=3.
5. Wrap: grant port 3, then release it with req=01001 (ports 0 and 3) -> ptr=4 and the winner is port 0 (gnt=00001), not port 3.
6. Async reset: assert rst=0 mid-packet between clock edges -> gnt, gnt_valid and gnt_idx clear immediately. After release with req=10000, gnt=10000 (search starts from ptr=0).
